// File: rtl/ysyx_23060208_ifu_pfq.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060208_ifu_pfq
// Brief    : Instruction fetch unit with a decoupled prefetch queue. Issues
//            sequential fetches (one outstanding at a time) to a
//            variable-latency instruction memory and buffers up to DEPTH
//            {pc, inst} pairs for the IDU. EXU redirects flush the queue and
//            discard any in-flight response.
// Ports    : clk, rst                      - clock, synchronous active-high reset
//            redirect_valid/redirect_pc    - EXU redirect
//            imem_req_valid/ready/addr     - fetch request channel
//            imem_resp_valid/data          - in-order fetch response channel
//            out_valid/ready/pc/inst       - queue head towards the IDU
//            perf_fetch_cnt/perf_stall_cnt - only with YSYX_23060208_IFU_PERF_EN
// Options  : YSYX_23060208_IFU_PERF_EN adds fetch and stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060208_ifu_pfq #(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
`ifdef YSYX_23060208_IFU_PERF_EN
    output logic [DATA_W-1:0] out_inst,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`else
    output logic [DATA_W-1:0] out_inst
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [ADDR_W-1:0]  c_RESET_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0]  c_PC_STEP  = ADDR_W'(4);
    localparam logic [c_CNT_W:0]   c_DEPTH    = (c_CNT_W + 1)'(DEPTH);

    localparam logic [1:0] c_ST_REQ     = 2'd0;
    localparam logic [1:0] c_ST_WAIT    = 2'd1;
    localparam logic [1:0] c_ST_DISCARD = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  req_pc_q;
    logic [c_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [c_CNT_W-1:0] count_q;
    logic [ADDR_W-1:0]  pc_mem_q   [DEPTH];
    logic [DATA_W-1:0]  inst_mem_q [DEPTH];

    logic w_in_wait;
    logic w_has_space;
    logic w_req_fire;
    logic w_push;
    logic w_pop;

    // An outstanding request reserves a slot, so the queue cannot overflow
    // when its response lands.
    assign w_in_wait   = (state_q == c_ST_WAIT);
    assign w_has_space = ({1'b0, count_q} + {{c_CNT_W{1'b0}}, w_in_wait}) < c_DEPTH;

    assign imem_req_valid = !rst && (state_q == c_ST_REQ) && w_has_space && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // A response coinciding with a redirect belongs to the wrong path.
    assign w_push = w_in_wait && imem_resp_valid && !redirect_valid;

    assign out_valid = !rst && (count_q != '0) && !redirect_valid;
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_inst  = inst_mem_q[rd_ptr_q];
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            c_ST_REQ: begin
                if (w_req_fire) begin
                    state_d    = c_ST_WAIT;
                    fetch_pc_d = fetch_pc_q + c_PC_STEP;
                end
            end
            c_ST_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = c_ST_REQ;
                end else if (redirect_valid) begin
                    // Response still in flight: it must be swallowed first.
                    state_d = c_ST_DISCARD;
                end
            end
            c_ST_DISCARD: begin
                if (imem_resp_valid) begin
                    state_d = c_ST_REQ;
                end
            end
            default: state_d = c_ST_REQ;
        endcase
        // The request is masked during a redirect, so this never collides
        // with the sequential increment above.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_ST_REQ;
            fetch_pc_q <= c_RESET_PC;
            req_pc_q   <= c_RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            if (w_req_fire) begin
                req_pc_q <= fetch_pc_q;
            end
        end
    end

    // Queue bookkeeping; a redirect flushes everything next cycle.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                count_q <= count_q - c_CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: entries are only observed while count_q covers them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
            inst_mem_q[wr_ptr_q] <= imem_resp_data;
        end
    end

`ifdef YSYX_23060208_IFU_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (w_push) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if ((state_q == c_ST_REQ) && !w_has_space) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060208_ifu_pfq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060208_ifu_pfq
// Brief    : Self-checking bench for the prefetch-queue IFU. A transaction
//            model (expected entry queue, outstanding/stale request flag and
//            next fetch address) plus a variable-latency memory model drive
//            directed scenarios and a long randomized run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060208_ifu_pfq;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
`ifdef YSYX_23060208_IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    ysyx_23060208_ifu_pfq #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .DEPTH   (DEPTH),
        .RESET_PC(RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
`ifdef YSYX_23060208_IFU_PERF_EN
        .out_inst       (out_inst),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`else
        .out_inst       (out_inst)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    // Reference model state
    ent_t        mq[$];
    bit          m_out;
    bit          m_stale;
    logic [31:0] m_req_pc;
    logic [31:0] m_fetch;
    int          exp_fetch;
    int          exp_stall;

    // Memory model state
    bit          mem_busy;
    int          mem_wait;
    logic [31:0] mem_addr;
    int          lat_cfg;   // <0 selects a random latency 0..3

    task automatic reset_model();
        mq.delete();
        m_out     = 1'b0;
        m_stale   = 1'b0;
        m_req_pc  = RST_PC;
        m_fetch   = RST_PC;
        exp_fetch = 0;
        exp_stall = 0;
        mem_busy  = 1'b0;
        mem_wait  = 0;
        mem_addr  = '0;
    endtask

    // Called at the negedge: applies this cycle's events to the models,
    // crosses the posedge and drives the memory response for the next cycle.
    task automatic advance();
        bit hs, rsp, pop;
        hs  = imem_req_valid && imem_req_ready;
        rsp = imem_resp_valid;
        pop = out_valid && out_ready;
        if (rst) begin
            reset_model();
        end else begin
            if (!m_out && mq.size() >= DEPTH) exp_stall++;
            if (pop && mq.size() != 0) void'(mq.pop_front());
            if (rsp) begin
                if (m_out && !m_stale && !redirect_valid) begin
                    mq.push_back({m_req_pc, imem_resp_data});
                    exp_fetch++;
                end
                m_out    = 1'b0;
                mem_busy = 1'b0;
            end else if (mem_busy && mem_wait > 0) begin
                mem_wait--;
            end
            if (hs) begin
                m_out    = 1'b1;
                m_stale  = 1'b0;
                m_req_pc = imem_req_addr;
                m_fetch  = m_fetch + 32'd4;
                mem_busy = 1'b1;
                mem_addr = imem_req_addr;
                mem_wait = (lat_cfg < 0) ? int'($urandom_range(3, 0)) : lat_cfg;
            end
            if (redirect_valid) begin
                if (m_out) m_stale = 1'b1;
                mq.delete();
                m_fetch = redirect_pc;
            end
        end
        @(posedge clk);
        #1;
        imem_resp_valid = mem_busy && (mem_wait == 0);
        imem_resp_data  = imem_resp_valid ? (mem_addr ^ 32'hFFFF_FFFF) : $urandom;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        out_ready      = 1'b0;
        repeat (2) begin
            @(negedge clk);
            advance();
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks += 2;
            if (imem_req_valid !== 1'b0) begin
                failures++; $display("FAIL reset_req_valid got=%b want=0", imem_req_valid);
            end
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
            end
            advance();
        end
        rst = 1'b0;
        @(negedge clk);
        checks += 3;
        if (imem_req_valid !== 1'b1) begin
            failures++; $display("FAIL first_req_valid got=%b want=1", imem_req_valid);
        end
        if (imem_req_addr !== RST_PC) begin
            failures++; $display("FAIL first_req_addr got=%h want=%h", imem_req_addr, RST_PC);
        end
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL post_reset_out_valid got=%b want=0", out_valid);
        end
`ifdef YSYX_23060208_IFU_PERF_EN
        checks += 2;
        if (perf_fetch_cnt !== 32'd0) begin
            failures++; $display("FAIL reset_perf_fetch got=%0d want=0", perf_fetch_cnt);
        end
        if (perf_stall_cnt !== 32'd0) begin
            failures++; $display("FAIL reset_perf_stall got=%0d want=0", perf_stall_cnt);
        end
`endif
        advance();
    endtask

    task automatic test_sequential();
        int          npop;
        logic [31:0] exp;
        do_reset();
        lat_cfg        = 0;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        npop           = 0;
        for (int cyc = 0; cyc < 40 && npop < 3; cyc++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                exp = RST_PC + 32'(4 * npop);
                checks += 2;
                if (out_pc !== exp) begin
                    failures++; $display("FAIL seq_pc[%0d] got=%h want=%h", npop, out_pc, exp);
                end
                if (out_inst !== ~exp) begin
                    failures++; $display("FAIL seq_inst[%0d] got=%h want=%h", npop, out_inst, ~exp);
                end
                npop++;
            end
            advance();
        end
        checks++;
        if (npop != 3) begin
            failures++; $display("FAIL seq_timeout pops=%0d want=3", npop);
        end
    endtask

    task automatic test_backpressure();
        int hs_cnt;
        do_reset();
        lat_cfg        = 0;
        imem_req_ready = 1'b1;
        out_ready      = 1'b0;
        hs_cnt         = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) hs_cnt++;
            if (out_valid) begin
                checks++;
                if (out_pc !== RST_PC) begin
                    failures++; $display("FAIL bp_head_stable got=%h want=%h", out_pc, RST_PC);
                end
            end
            advance();
        end
        @(negedge clk);
        checks += 3;
        if (hs_cnt != DEPTH) begin
            failures++; $display("FAIL bp_requests got=%0d want=%0d", hs_cnt, DEPTH);
        end
        if (imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL bp_full_req_valid got=%b want=0", imem_req_valid);
        end
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL bp_full_out_valid got=%b want=1", out_valid);
        end
`ifdef YSYX_23060208_IFU_PERF_EN
        checks += 2;
        if (perf_fetch_cnt !== 32'd4) begin
            failures++; $display("FAIL bp_perf_fetch got=%0d want=4", perf_fetch_cnt);
        end
        if (perf_stall_cnt !== 32'(exp_stall)) begin
            failures++; $display("FAIL bp_perf_stall got=%0d want=%0d", perf_stall_cnt, exp_stall);
        end
`endif
        advance();
        out_ready = 1'b1;
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL bp_pop_valid got=%b want=1", out_valid);
        end
        if (imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL bp_pop_cycle_req got=%b want=0", imem_req_valid);
        end
        advance();
        out_ready = 1'b0;
        @(negedge clk);
        checks += 2;
        if (imem_req_valid !== 1'b1) begin
            failures++; $display("FAIL bp_refill_req got=%b want=1", imem_req_valid);
        end
        if (imem_req_addr !== 32'h8000_0010) begin
            failures++; $display("FAIL bp_refill_addr got=%h want=80000010", imem_req_addr);
        end
        advance();
    endtask

    task automatic test_redirect_wait();
        bit          found, seen_req, seen_pop;
        int          resp_cyc, req_cyc, bad;
        logic [31:0] first_pop_pc, first_req_addr;
        do_reset();
        lat_cfg        = 3;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        found          = 1'b0;
        for (int cyc = 0; cyc < 40 && !found; cyc++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready && imem_req_addr == RST_PC + 32'd4) found = 1'b1;
            advance();
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL rw_no_req_8000_0004 got=none want=request");
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL rw_req_during_redirect got=%b want=0", imem_req_valid);
        end
        advance();
        redirect_valid = 1'b0;
        seen_req = 1'b0; seen_pop = 1'b0;
        resp_cyc = -1; req_cyc = -1; bad = 0;
        first_pop_pc = '0; first_req_addr = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (imem_resp_valid && resp_cyc < 0) resp_cyc = cyc;
            if (imem_req_valid && !seen_req) begin
                seen_req = 1'b1; req_cyc = cyc; first_req_addr = imem_req_addr;
            end
            if (out_valid && out_ready) begin
                if (out_pc == RST_PC + 32'd4) bad++;
                if (!seen_pop) begin seen_pop = 1'b1; first_pop_pc = out_pc; end
            end
            advance();
        end
        checks += 4;
        if (!seen_req || first_req_addr !== 32'h8000_0100) begin
            failures++; $display("FAIL rw_next_req_addr got=%h want=80000100", first_req_addr);
        end
        if (req_cyc != resp_cyc + 1) begin
            failures++; $display("FAIL rw_req_after_stale got=%0d want=%0d", req_cyc, resp_cyc + 1);
        end
        if (bad != 0) begin
            failures++; $display("FAIL rw_stale_entry_seen got=%0d want=0", bad);
        end
        if (!seen_pop || first_pop_pc !== 32'h8000_0100) begin
            failures++; $display("FAIL rw_first_pop got=%h want=80000100", first_pop_pc);
        end
    endtask

    task automatic test_redirect_with_resp();
        bit found, seen_pop;
        do_reset();
        lat_cfg        = 0;
        imem_req_ready = 1'b1;
        out_ready      = 1'b0;
        found          = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (imem_resp_valid && mq.size() == 2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            advance();
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL rr_setup_timeout got=none want=resp_with_2_queued");
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL rr_out_valid_redirect got=%b want=0", out_valid);
        end
        if (imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL rr_req_redirect got=%b want=0", imem_req_valid);
        end
        advance();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks += 3;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL rr_flush got=%b want=0", out_valid);
        end
        if (imem_req_valid !== 1'b1) begin
            failures++; $display("FAIL rr_new_req_valid got=%b want=1", imem_req_valid);
        end
        if (imem_req_addr !== 32'h8000_0200) begin
            failures++; $display("FAIL rr_new_req_addr got=%h want=80000200", imem_req_addr);
        end
        advance();
        out_ready = 1'b1;
        seen_pop  = 1'b0;
        for (int cyc = 0; cyc < 20 && !seen_pop; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                seen_pop = 1'b1;
                checks += 2;
                if (out_pc !== 32'h8000_0200) begin
                    failures++; $display("FAIL rr_pop_pc got=%h want=80000200", out_pc);
                end
                if (out_inst !== ~32'h8000_0200) begin
                    failures++; $display("FAIL rr_pop_inst got=%h want=%h", out_inst, ~32'h8000_0200);
                end
            end
            advance();
        end
        checks++;
        if (!seen_pop) begin
            failures++; $display("FAIL rr_pop_timeout got=none want=entry");
        end
    endtask

    task automatic test_req_stall();
        bit seen;
        do_reset();
        lat_cfg        = 0;
        imem_req_ready = 1'b0;
        out_ready      = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            checks += 2;
            if (imem_req_valid !== 1'b1) begin
                failures++; $display("FAIL rs_hold_valid[%0d] got=%b want=1", cyc, imem_req_valid);
            end
            if (imem_req_addr !== RST_PC) begin
                failures++; $display("FAIL rs_hold_addr[%0d] got=%h want=%h", cyc, imem_req_addr, RST_PC);
            end
            advance();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL rs_redirect_req got=%b want=0", imem_req_valid);
        end
        advance();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0300) begin
            failures++; $display("FAIL rs_switch_addr got=%b/%h want=1/80000300", imem_req_valid, imem_req_addr);
        end
        advance();
        imem_req_ready = 1'b1;
        @(negedge clk);
        advance();
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            if (imem_req_valid) begin
                seen = 1'b1;
                checks++;
                if (imem_req_addr !== 32'h8000_0304) begin
                    failures++; $display("FAIL rs_next_addr got=%h want=80000304", imem_req_addr);
                end
            end
            advance();
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL rs_next_timeout got=none want=request");
        end
    endtask

    task automatic test_random();
        bit exp_req, exp_out;
        do_reset();
        lat_cfg = -1;
        for (int cyc = 0; cyc < 4000 && failures < 20; cyc++) begin
            rst            = (cyc >= 2000 && cyc < 2002);
            imem_req_ready = ($urandom_range(99, 0) < 70);
            out_ready      = ($urandom_range(99, 0) < 60);
            redirect_valid = !rst && ($urandom_range(99, 0) < 5);
            if ($urandom_range(7, 0) == 0)
                redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(3, 0) * 4);
            else
                redirect_pc = $urandom & 32'hFFFF_FFFC;
            @(negedge clk);
            exp_req = !rst && !m_out && !redirect_valid && (mq.size() < DEPTH);
            exp_out = !rst && (mq.size() != 0) && !redirect_valid;
            checks += 2;
            if (imem_req_valid !== exp_req) begin
                failures++; $display("FAIL rnd_req_valid cyc=%0d got=%b want=%b", cyc, imem_req_valid, exp_req);
            end
            if (out_valid !== exp_out) begin
                failures++; $display("FAIL rnd_out_valid cyc=%0d got=%b want=%b", cyc, out_valid, exp_out);
            end
            if (exp_req) begin
                checks++;
                if (imem_req_addr !== m_fetch) begin
                    failures++; $display("FAIL rnd_req_addr cyc=%0d got=%h want=%h", cyc, imem_req_addr, m_fetch);
                end
            end
            if (exp_out) begin
                checks += 2;
                if (out_pc !== mq[0].pc) begin
                    failures++; $display("FAIL rnd_out_pc cyc=%0d got=%h want=%h", cyc, out_pc, mq[0].pc);
                end
                if (out_inst !== mq[0].inst) begin
                    failures++; $display("FAIL rnd_out_inst cyc=%0d got=%h want=%h", cyc, out_inst, mq[0].inst);
                end
            end
            advance();
        end
        rst            = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
`ifdef YSYX_23060208_IFU_PERF_EN
        checks += 2;
        if (perf_fetch_cnt !== 32'(exp_fetch)) begin
            failures++; $display("FAIL rnd_perf_fetch got=%0d want=%0d", perf_fetch_cnt, exp_fetch);
        end
        if (perf_stall_cnt !== 32'(exp_stall)) begin
            failures++; $display("FAIL rnd_perf_stall got=%0d want=%0d", perf_stall_cnt, exp_stall);
        end
`endif
        advance();
    endtask

    initial begin
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        out_ready       = 1'b0;
        lat_cfg         = 0;
        reset_model();
        #1;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_with_resp();
        test_req_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
